fifo_512_40bit_drain: RTL

Read-side controller for the 512x40 FIFO. Pops words from the FIFO's `empty`/`re`/`dout` port and presents them downstream as a 40-bit valid/ready stream. Internally it is a 2-entry output buffer with in-flight read accounting, so it sustains one word per cycle across the FIFO's one-cycle read latency. It sits between the FIFO and any consumer that may stall.

---
 rtl/fifo_512_40bit_drain.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fifo_512_40bit_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_512_40bit_drain
//
// Read-side controller for the 512x40 FIFO. It pops words through the FIFO's
// empty/re/dout port, which has one cycle of read latency. It presents them
// downstream as a valid/ready stream.
//
// A 2-entry buffer (head + skid) plus one in-flight read slot lets it sustain
// one word per cycle while the consumer may stall at any time.
//
// Optional feature (macro FIFO_DRAIN_LAST_EN):
//   - A 16-bit pop counter marks every BURST_LEN-th word with o_m_last.
//   - With the macro undefined, o_m_last is constant 0.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous reset, active low
//   i_en          drain enable; gates new FIFO reads only
//   i_clr         synchronous flush, active high
//   i_fifo_empty  FIFO empty flag
//   i_fifo_dout   FIFO read data, valid the cycle after o_fifo_re
//   o_fifo_re     FIFO read strobe
//   o_fifo_clr    FIFO clear, equal to i_clr
//   o_m_valid     output word valid
//   o_m_data      output word
//   o_m_last      last word of burst
//   i_m_ready     downstream accept
// -----------------------------------------------------------------------------
module fifo_512_40bit_drain #(
  parameter int DW        = 40,
  parameter int BURST_LEN = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_fifo_empty,
  input  logic [DW-1:0] i_fifo_dout,
  output logic          o_fifo_re,
  output logic          o_fifo_clr,
  output logic          o_m_valid,
  output logic [DW-1:0] o_m_data,
  output logic          o_m_last,
  input  logic          i_m_ready
);

  if (BURST_LEN < 2 || BURST_LEN > 65535) begin : g_burst_len_check
    $error("fifo_512_40bit_drain: BURST_LEN must be within 2..65535");
  end

  logic [1:0]    r_occ;        // words held in head/skid
  logic          r_inflight;   // a read was issued last cycle
  logic [DW-1:0] r_head_data;
  logic          r_head_last;
  logic [DW-1:0] r_skid_data;
  logic          r_skid_last;

  logic          w_flush;
  logic          w_pop;
  logic [2:0]    w_level;
  logic [1:0]    w_occ_next;
  logic          w_head_take;
  logic          w_cap_last;

  // Reset and clr have identical effect on the buffer state.
  assign w_flush = ~i_rst | i_clr;
  assign w_pop   = o_m_valid & i_m_ready;

  // Words that would still be held or in flight after this cycle's pop.
  // Because a pop implies r_occ >= 1, this never underflows.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign o_fifo_re  = i_rst & ~i_clr & i_en & ~i_fifo_empty & (w_level < 3'd2);
  assign o_fifo_clr = i_clr;

  assign o_m_valid = (r_occ != 2'd0);
  assign o_m_data  = r_head_data;
  assign o_m_last  = r_head_last;

  assign w_occ_next = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

  // The arriving word goes to the head when the head is empty, or when the
  // head is being popped with nothing queued behind it.
  assign w_head_take = (r_occ == 2'd0) | ((r_occ == 2'd1) & w_pop);

`ifdef FIFO_DRAIN_LAST_EN
  localparam logic [15:0] LP_LAST_IDX = 16'(BURST_LEN - 1);

  logic [15:0] r_cnt;       // burst position of the head word
  logic [16:0] w_cap_idx;

  // An arriving word sits r_occ places behind the head, so its burst position
  // is r_cnt + r_occ. Arrival implies r_occ <= 1, so a single compare suffices:
  // r_cnt + r_occ can reach BURST_LEN, but that is position 0 of the next burst.
  assign w_cap_idx  = {1'b0, r_cnt} + {15'd0, r_occ};
  assign w_cap_last = (w_cap_idx == {1'b0, LP_LAST_IDX});

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= (r_cnt == LP_LAST_IDX) ? 16'd0 : r_cnt + 16'd1;
    end
  end
`else
  assign w_cap_last = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values of the others, independent of
  // statement order.
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
    end else begin
      r_occ      <= w_occ_next;
      r_inflight <= o_fifo_re;
      // The skid shift happens only at r_occ == 2, and a head capture only at
      // r_occ < 2. The two never write the head in the same cycle.
      if (w_pop && (r_occ == 2'd2)) begin
        r_head_data <= r_skid_data;
        r_head_last <= r_skid_last;
      end
      if (r_inflight && w_head_take) begin
        r_head_data <= i_fifo_dout;
        r_head_last <= w_cap_last;
      end
    end
  end

  // NOTE: the skid payload has no reset. It is only read when r_occ == 2,
  // which requires a prior write, so a stale value is never observable.
  always_ff @(posedge i_clk) begin
    if (i_rst && !i_clr && r_inflight && !w_head_take) begin
      r_skid_data <= i_fifo_dout;
      r_skid_last <= w_cap_last;
    end
  end

endmodule
